// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 one-hot decoder: accepts a code over valid/ready, holds the
// matching one-hot line for HOLD_CYCLES, then forces zero for GAP_CYCLES.
module onehot_decoder_seq #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [2:0] code_in,
   input  logic       code_valid,
   output logic       code_ready,
   output logic [7:0] y,
   output logic       y_valid,
   output logic       busy,
   output logic       done
);

   localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CW_RAW  = $clog2(MAX_CNT + 1);
   localparam int unsigned CW      = (CW_RAW < 1) ? 1 : CW_RAW;

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Handshake and status flags decode straight from the registered state.
   assign code_ready = (state == IDLE) & enable;
   assign y_valid    = (state == DRIVE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state <= IDLE;
         y     <= 8'h00;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (code_valid) begin
                  y     <= 8'(1) << code_in;
                  cnt   <= HOLD_LOAD;
                  state <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  y    <= 8'h00;
                  done <= 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state <= GAP;
                     cnt   <= GAP_LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               y     <= 8'h00;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// checked against a timeline model, a vector table, a sweep and random traffic.
module tb_onehot_decoder_seq;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [2:0] code_in;
   logic       code_valid;

   logic       rdy0, yv0, bsy0, dn0;
   logic [7:0] y0;
   logic       rdy1, yv1, bsy1, dn1;
   logic [7:0] y1;

   onehot_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst), .enable(enable), .code_in(code_in),
      .code_valid(code_valid), .code_ready(rdy0), .y(y0),
      .y_valid(yv0), .busy(bsy0), .done(dn0));

   onehot_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .code_in(code_in),
      .code_valid(code_valid), .code_ready(rdy1), .y(y1),
      .y_valid(yv1), .busy(bsy1), .done(dn1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: each DUT is either inactive or at phase j = edges since its accept.
   int         hold [2] = '{4, 1};
   int         gap  [2] = '{1, 0};
   bit         act  [2] = '{0, 0};
   int         aed  [2] = '{0, 0};
   logic [2:0] mcode[2];
   int         n = 0;

   typedef struct {
      logic       r, e, v;
      logic [2:0] c;
      logic [7:0] y;
      logic       yv, b, d, rdy;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(input logic r, e, v, input logic [2:0] c,
                               input logic [7:0] ey, input logic eyv, eb, ed, erdy);
      vec_t t;
      t.r = r; t.e = e; t.v = v; t.c = c;
      t.y = ey; t.yv = eyv; t.b = eb; t.d = ed; t.rdy = erdy;
      return t;
   endfunction

   function automatic int enc(input logic [7:0] v);
      int r = -1;
      for (int i = 0; i < 8; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic cmp(input string name, input int actv, input int expv);
      n_cmp++;
      if (actv !== expv) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got 0x%0h want 0x%0h", name, n, actv, expv);
      end
   endtask

   function automatic logic [11:0] model_out(input int d);
      int j;
      logic [7:0] ey;
      logic eyv, eb, ed;
      ey = 8'h00; eyv = 1'b0; eb = 1'b0; ed = 1'b0;
      if (act[d]) begin
         j   = n - aed[d];
         eyv = (j < hold[d]);
         ey  = eyv ? (8'(1) << mcode[d]) : 8'h00;
         eb  = (j < hold[d] + gap[d]);
         ed  = (j == hold[d]);
      end
      return {ey, eyv, eb, ed, (!eb && enable)};
   endfunction

   task automatic check_model();
      logic [11:0] a0, a1;
      a0 = {y0, yv0, bsy0, dn0, rdy0};
      a1 = {y1, yv1, bsy1, dn1, rdy1};
      cmp("dut0_outputs", int'(a0), int'(model_out(0)));
      cmp("dut1_outputs", int'(a1), int'(model_out(1)));
      if (yv0) cmp("dut0_loopback", enc(y0), int'(mcode[0]));
      if (yv1) cmp("dut1_loopback", enc(y1), int'(mcode[1]));
   endtask

   task automatic step(input logic r, e, v, input logic [2:0] c);
      bit acc[2];
      @(negedge clk);
      rst = r; enable = e; code_valid = v; code_in = c;
      for (int d = 0; d < 2; d++)
         acc[d] = !r && e && v && (!act[d] || (n - aed[d] >= hold[d] + gap[d]));
      @(posedge clk);
      n++;
      for (int d = 0; d < 2; d++) begin
         if (r || !e) act[d] = 1'b0;
         else if (acc[d]) begin
            act[d] = 1'b1; aed[d] = n; mcode[d] = c;
         end
      end
      #1;
      check_model();
   endtask

   initial begin
      int k, last, cyc;
      logic prev;
      rst = 1'b1; enable = 1'b1; code_valid = 1'b0; code_in = 3'd0;

      // Reset, single decode, abort, stall and mid-GAP reset for the HOLD=4/GAP=1 instance.
      tbl[0]  = mk(1, 1, 1, 3'd5, 8'h00, 0, 0, 0, 1);
      tbl[1]  = mk(1, 1, 1, 3'd5, 8'h00, 0, 0, 0, 1);
      tbl[2]  = mk(0, 1, 1, 3'd5, 8'h20, 1, 1, 0, 0);
      tbl[3]  = mk(0, 1, 0, 3'd0, 8'h20, 1, 1, 0, 0);
      tbl[4]  = mk(0, 1, 0, 3'd0, 8'h20, 1, 1, 0, 0);
      tbl[5]  = mk(0, 1, 0, 3'd0, 8'h20, 1, 1, 0, 0);
      tbl[6]  = mk(0, 1, 0, 3'd0, 8'h00, 0, 1, 1, 0);
      tbl[7]  = mk(0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 1);
      tbl[8]  = mk(0, 1, 1, 3'd3, 8'h08, 1, 1, 0, 0);
      tbl[9]  = mk(0, 1, 0, 3'd3, 8'h08, 1, 1, 0, 0);
      tbl[10] = mk(0, 0, 0, 3'd3, 8'h00, 0, 0, 0, 0);
      tbl[11] = mk(0, 0, 1, 3'd6, 8'h00, 0, 0, 0, 0);
      tbl[12] = mk(0, 1, 1, 3'd6, 8'h40, 1, 1, 0, 0);
      tbl[13] = mk(0, 1, 1, 3'd7, 8'h40, 1, 1, 0, 0);
      tbl[14] = mk(0, 1, 1, 3'd7, 8'h40, 1, 1, 0, 0);
      tbl[15] = mk(0, 1, 1, 3'd7, 8'h40, 1, 1, 0, 0);
      tbl[16] = mk(0, 1, 1, 3'd7, 8'h00, 0, 1, 1, 0);
      tbl[17] = mk(0, 1, 1, 3'd7, 8'h00, 0, 0, 0, 1);
      tbl[18] = mk(0, 1, 1, 3'd7, 8'h80, 1, 1, 0, 0);
      tbl[19] = mk(0, 1, 0, 3'd0, 8'h80, 1, 1, 0, 0);
      tbl[20] = mk(0, 1, 0, 3'd0, 8'h80, 1, 1, 0, 0);
      tbl[21] = mk(0, 1, 0, 3'd0, 8'h80, 1, 1, 0, 0);
      tbl[22] = mk(0, 1, 0, 3'd0, 8'h00, 0, 1, 1, 0);
      tbl[23] = mk(1, 1, 0, 3'd0, 8'h00, 0, 0, 0, 1);
      tbl[24] = mk(0, 1, 0, 3'd0, 8'h00, 0, 0, 0, 1);

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].c);
         cmp($sformatf("vec%0d_dut0", i),
             int'({y0, yv0, bsy0, dn0, rdy0}),
             int'({tbl[i].y, tbl[i].yv, tbl[i].b, tbl[i].d, tbl[i].rdy}));
      end

      // Back-to-back sweep with code_valid held: accepts must be 6 cycles apart.
      step(1, 1, 0, 3'd0);
      k = 0; last = 0; prev = 1'b0;
      for (cyc = 0; cyc < 80 && k < 8; cyc++) begin
         step(0, 1, 1, 3'(k));
         if (yv0 && !prev) begin
            cmp($sformatf("sweep_y%0d", k), int'(y0), int'(8'(1) << k));
            cmp($sformatf("sweep_enc%0d", k), enc(y0), k);
            if (k > 0) cmp($sformatf("sweep_gap%0d", k), cyc - last, 6);
            last = cyc;
            k++;
         end
         prev = yv0;
      end
      cmp("sweep_complete", k, 8);

      // Random traffic against the model on both instances.
      step(1, 1, 0, 3'd0);
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 2) != 0), 3'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
